alu_16b: RTL and testbench
==========================

ALU_16B -- requirements
Module: alu_16b

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; all values below assume 16.
REQ-002 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port A, input, 16, first operand (unsigned).
REQ-005 SHALL have port B, input, 16, second operand (unsigned).
REQ-006 SHALL have port ALU_FUN, input, 4, operation select.
REQ-007 SHALL have port ALU_OUT, output, 16, registered result.
REQ-008 SHALL have port Carry_Flag, output, 1, registered carry/borrow of add/sub.
REQ-009 SHALL have ports Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, output, 1 each, operation-class indicators.

Function
REQ-010 SHALL compute the next result combinationally from A, B, ALU_FUN and load it into ALU_OUT on every rising CLK edge when RST=0; latency is one cycle, with no handshake or enable.
REQ-011 SHALL decode ALU_FUN as follows:
- 0: A+B.
- 1: A-B.
- 2: A*B, low 16 bits.
- 3: A/B, integer quotient.
- 4: A&B.
- 5: A|B.
- 6: ~(A&B).
- 7: ~(A|B).
- 8: A^B.
- 9: ~(A^B).
- 10: 1 if A==B, else 0.
- 11: 2 if A>B, else 0.
- 12: 3 if A<B, else 0.
- 13: A>>1, logical.
- 14: A<<1, dropping the MSB.
- 15: 0.
REQ-012 SHALL register Carry_Flag on the same edge as ALU_OUT:
- code 0: bit 16 of the 17-bit sum.
- code 1: bit 16 of the 17-bit difference (1 = borrow, i.e. A<B).
- all other codes: 0.
REQ-013 SHALL drive the class flags combinationally from ALU_FUN:
- Arith_Flag=1 for codes 0-3.
- Logic_Flag=1 for codes 4-9.
- CMP_Flag=1 for codes 10-12.
- Shift_Flag=1 for codes 13-14.
- Exactly one flag is high for codes 0-14; all are 0 for code 15.
REQ-014 SHALL produce ALU_OUT=0 for division with B=0, with no error indication.
REQ-015 SHALL wrap add/sub results modulo 2^16; product bits above 15 are discarded.
REQ-016 SHALL treat all comparisons as unsigned.

Reset
REQ-017 SHALL, on a rising CLK edge with RST=1, set ALU_OUT=0 and Carry_Flag=0, overriding any operation.
REQ-018 SHALL leave the class flags driven by ALU_FUN while RST=1, because they are combinational.
REQ-019 SHALL resume normal operation on the first rising edge with RST=0, with no extra recovery cycle.

Configuration
REQ-020 SHALL gate multiply/divide with macro ALU_16B_MULDIV_EN.
REQ-021 SHALL, with ALU_16B_MULDIV_EN defined, implement codes 2 and 3 per REQ-011.
REQ-022 SHALL, without ALU_16B_MULDIV_EN, produce ALU_OUT=0 for codes 2 and 3 and instantiate no multiplier or divider; Arith_Flag still asserts for codes 2 and 3.

Structure
REQ-023 SHALL place the 4-bit opcode constants (ADD..SHL, NOP=15) and the width constant in shared package alu_16b_pkg.
REQ-024 SHALL use one combinational sub-module, alu_16b_core, that computes the 17-bit result and the class flags.
REQ-025 SHALL keep the result and carry registers, and the reset logic, in the top module alu_16b.

Verification
REQ-026 SHALL cover RST=1 for one edge with A=12, B=5, ALU_FUN=0 -> ALU_OUT=0, Carry_Flag=0, Arith_Flag=1.
REQ-027 SHALL cover A=12, B=5, sweeping codes 0-15 one per cycle -> ALU_OUT one cycle after each code, in order:
- 17, 7, 60, 2.
- 4, 13, 0xFFFB, 0xFFF2, 9, 0xFFF6.
- 0, 2, 0.
- 6, 24, 0.
- Class flags matching REQ-013 throughout.
REQ-028 SHALL cover A=0xFFFF, B=1, code 0 -> ALU_OUT=0, Carry_Flag=1; then A=5, B=12, code 1 -> ALU_OUT=0xFFF9, Carry_Flag=1.
REQ-029 SHALL cover A=7, B=7:
- code 10 -> 1.
- code 11 -> 0.
- code 12 -> 0.
- then A=3, B=9, code 12 -> 3.
REQ-030 SHALL cover A=100, B=0, code 3 -> ALU_OUT=0; and A=0x8001, codes 13 and 14 -> 0x4000 and 0x0002.
REQ-031 SHALL cover RST=1 asserted mid-sweep while ALU_OUT=60 -> ALU_OUT=0 on that edge, with correct results resuming on the next edge after RST=0.

Source files
------------

// File: rtl/alu_16b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_16b_pkg
// Description : Shared width constant, opcode encoding and helpers for the
//               16-bit registered ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_16b_pkg;

  // Default operand/result width
  localparam int unsigned ALU_WIDTH = 16;

  // Width of the operation-select field
  localparam int unsigned ALU_OP_W = 4;

  // Operation select encoding
  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_XOR  = 4'd8,
    OP_XNOR = 4'd9,
    OP_EQ   = 4'd10,
    OP_GT   = 4'd11,
    OP_LT   = 4'd12,
    OP_SHR  = 4'd13,
    OP_SHL  = 4'd14,
    OP_NOP  = 4'd15
  } alu_op_e;

  // Only add and subtract produce a meaningful carry/borrow bit
  function automatic logic is_carry_op(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage : alu_16b_pkg
`default_nettype wire

// File: rtl/alu_16b_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_16b_core
// Description : Purely combinational datapath of the ALU. Produces a
//               (WIDTH+1)-bit result whose MSB is the carry/borrow for
//               add/sub (zero for every other operation), plus the
//               operation-class flags decoded from the opcode.
//               Optional feature macro: ALU_16B_MULDIV_EN enables the
//               multiplier and divider for codes 2 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_16b_core
  import alu_16b_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] alu_fun,
  output logic [WIDTH:0]      result,
  output logic                arith_flag,
  output logic                logic_flag,
  output logic                cmp_flag,
  output logic                shift_flag
);

  localparam int unsigned RW = WIDTH + 1;

  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] quot;

`ifdef ALU_16B_MULDIV_EN
  // Low half of the product; upper bits are discarded by the result width
  assign prod_lo = a * b;
  // Division by zero quietly yields zero
  assign quot    = (b == '0) ? '0 : (a / b);
`else
  // Multiply/divide disabled: no arithmetic hardware, codes 2/3 yield zero
  assign prod_lo = '0;
  assign quot    = '0;
`endif

  // Result select; bit WIDTH carries out of add or borrows out of subtract
  always_comb begin
    result = '0;
    case (alu_op_e'(alu_fun))
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      OP_SUB:  result = {1'b0, a} - {1'b0, b};
      OP_MUL:  result = {1'b0, prod_lo};
      OP_DIV:  result = {1'b0, quot};
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      OP_NAND: result = {1'b0, ~(a & b)};
      OP_NOR:  result = {1'b0, ~(a | b)};
      OP_XOR:  result = {1'b0, a ^ b};
      OP_XNOR: result = {1'b0, ~(a ^ b)};
      OP_EQ:   result = (a == b) ? RW'(1) : '0;
      OP_GT:   result = (a >  b) ? RW'(2) : '0;
      OP_LT:   result = (a <  b) ? RW'(3) : '0;
      OP_SHR:  result = {2'b00, a[WIDTH-1:1]};
      OP_SHL:  result = {1'b0, a[WIDTH-2:0], 1'b0};
      default: result = '0;
    endcase
  end

  // Operation-class indicators; exactly one is set except for NOP
  always_comb begin
    arith_flag = 1'b0;
    logic_flag = 1'b0;
    cmp_flag   = 1'b0;
    shift_flag = 1'b0;
    case (alu_op_e'(alu_fun))
      OP_ADD, OP_SUB, OP_MUL, OP_DIV:                    arith_flag = 1'b1;
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:   logic_flag = 1'b1;
      OP_EQ, OP_GT, OP_LT:                               cmp_flag   = 1'b1;
      OP_SHR, OP_SHL:                                    shift_flag = 1'b1;
      default: ;
    endcase
  end

endmodule : alu_16b_core
`default_nettype wire

// File: rtl/alu_16b.sv
`default_nettype none
// ============================================================================
// Module      : alu_16b
// Description : 16-bit ALU with a one-cycle registered result and carry.
//               Class flags are combinational from ALU_FUN and therefore
//               remain live during reset.
//               Optional feature macro: ALU_16B_MULDIV_EN (multiply/divide).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_16b
  import alu_16b_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] ALU_FUN,
  output logic [WIDTH-1:0]    ALU_OUT,
  output logic                Carry_Flag,
  output logic                Arith_Flag,
  output logic                Logic_Flag,
  output logic                CMP_Flag,
  output logic                Shift_Flag
);

  logic [WIDTH:0]   core_result;
  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] alu_out_q;
  logic             carry_d;
  logic             carry_q;

  alu_16b_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a          (A),
    .b          (B),
    .alu_fun    (ALU_FUN),
    .result     (core_result),
    .arith_flag (Arith_Flag),
    .logic_flag (Logic_Flag),
    .cmp_flag   (CMP_Flag),
    .shift_flag (Shift_Flag)
  );

  // Next-state: split the core result into data and carry/borrow
  always_comb begin
    alu_out_d = core_result[WIDTH-1:0];
    carry_d   = is_carry_op(alu_op_e'(ALU_FUN)) ? core_result[WIDTH] : 1'b0;
  end

  // Result registers with synchronous reset overriding any operation
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
    end
  end

  assign ALU_OUT    = alu_out_q;
  assign Carry_Flag = carry_q;

endmodule : alu_16b
`default_nettype wire

// File: tb/tb_alu_16b.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_16b
// Description : Directed self-checking bench for alu_16b. Expected results
//               are queued when stimulus is applied and compared once the
//               registered output appears one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_16b;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        Carry_Flag;
  logic        Arith_Flag;
  logic        Logic_Flag;
  logic        CMP_Flag;
  logic        Shift_Flag;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] out;
    logic        c;
    string       tag;
  } exp_t;

  exp_t sb[$];

  alu_16b #(.WIDTH(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .Carry_Flag (Carry_Flag),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .Shift_Flag (Shift_Flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected {carry, result} for one operation
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] f);
    logic [16:0] r;
    r = '0;
    case (f)
      4'd0:  r = {1'b0, a} + {1'b0, b};
      4'd1:  r = {1'b0, a} - {1'b0, b};
`ifdef ALU_16B_MULDIV_EN
      4'd2:  r = {1'b0, 16'(a * b)};
      4'd3:  r = (b == 16'd0) ? 17'd0 : {1'b0, a / b};
`endif
      4'd4:  r = {1'b0, a & b};
      4'd5:  r = {1'b0, a | b};
      4'd6:  r = {1'b0, ~(a & b)};
      4'd7:  r = {1'b0, ~(a | b)};
      4'd8:  r = {1'b0, a ^ b};
      4'd9:  r = {1'b0, ~(a ^ b)};
      4'd10: r = (a == b) ? 17'd1 : 17'd0;
      4'd11: r = (a > b)  ? 17'd2 : 17'd0;
      4'd12: r = (a < b)  ? 17'd3 : 17'd0;
      4'd13: r = {1'b0, a >> 1};
      4'd14: r = {1'b0, a << 1};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, expv);
    end
  endtask

  // Apply one operation, check the combinational flags, then the registered result
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                      input logic rst, input logic [15:0] exp_out, input logic exp_c,
                      input string tag);
    exp_t e;
    exp_t got;
    logic [3:0] fl_exp;
    @(negedge CLK);
    A = a; B = b; ALU_FUN = f; RST = rst;
    e.out = exp_out; e.c = exp_c; e.tag = tag;
    sb.push_back(e);
    #1;
    fl_exp = {(f <= 4'd3), (f >= 4'd4 && f <= 4'd9), (f >= 4'd10 && f <= 4'd12),
              (f == 4'd13 || f == 4'd14)};
    check({tag, "_flags"}, {12'd0, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag},
          {12'd0, fl_exp});
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      got = sb.pop_front();
      check({got.tag, "_out"}, ALU_OUT, got.out);
      check({got.tag, "_carry"}, {15'd0, Carry_Flag}, {15'd0, got.c});
    end
  endtask

  // Shorthand: expected values from the model, reset low
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                    input string tag);
    logic [16:0] m;
    m = model(a, b, f);
    step(a, b, f, 1'b0, m[15:0], m[16], tag);
  endtask

  logic [15:0] sweep_tbl [16];

  initial begin
    sweep_tbl = '{16'd17, 16'd7, 16'd60, 16'd2, 16'd4, 16'd13, 16'hFFFB, 16'hFFF2,
                  16'd9, 16'hFFF6, 16'd0, 16'd2, 16'd0, 16'd6, 16'd24, 16'd0};
`ifndef ALU_16B_MULDIV_EN
    sweep_tbl[2] = 16'd0;
    sweep_tbl[3] = 16'd0;
`endif
    RST = 1'b1; A = 16'd0; B = 16'd0; ALU_FUN = 4'd15;

    // Reset overrides the add; Arith_Flag still follows ALU_FUN
    step(16'd12, 16'd5, 4'd0, 1'b1, 16'd0, 1'b0, "rst_add");
    step(16'd12, 16'd5, 4'd0, 1'b1, 16'd0, 1'b0, "rst_hold");

    // Full opcode sweep with A=12, B=5
    for (int i = 0; i < 16; i++) begin
      step(16'd12, 16'd5, 4'(i), 1'b0, sweep_tbl[i], 1'b0, $sformatf("sweep%0d", i));
    end

    // Carry and borrow boundaries
    step(16'hFFFF, 16'd1, 4'd0, 1'b0, 16'd0, 1'b1, "add_wrap");
    step(16'd5, 16'd12, 4'd1, 1'b0, 16'hFFF9, 1'b1, "sub_borrow");
    op(16'hFFFF, 16'hFFFF, 4'd0, "add_max");
    op(16'h1234, 16'h1234, 4'd1, "sub_equal");

    // Unsigned comparisons on equal and ordered operands
    step(16'd7, 16'd7, 4'd10, 1'b0, 16'd1, 1'b0, "eq_7_7");
    step(16'd7, 16'd7, 4'd11, 1'b0, 16'd0, 1'b0, "gt_7_7");
    step(16'd7, 16'd7, 4'd12, 1'b0, 16'd0, 1'b0, "lt_7_7");
    step(16'd3, 16'd9, 4'd12, 1'b0, 16'd3, 1'b0, "lt_3_9");
    op(16'h8000, 16'h0001, 4'd11, "gt_unsigned");

    // Divide by zero and shift edges
    step(16'd100, 16'd0, 4'd3, 1'b0, 16'd0, 1'b0, "div_zero");
    step(16'h8001, 16'd0, 4'd13, 1'b0, 16'h4000, 1'b0, "shr_8001");
    step(16'h8001, 16'd0, 4'd14, 1'b0, 16'h0002, 1'b0, "shl_8001");
    op(16'hABCD, 16'h0100, 4'd2, "mul_trunc");
    op(16'd1000, 16'd7, 4'd3, "div_1000_7");

    // Reset asserted mid-sweep right after the product is on ALU_OUT
    for (int i = 0; i < 3; i++) begin
      step(16'd12, 16'd5, 4'(i), 1'b0, sweep_tbl[i], 1'b0, $sformatf("resweep%0d", i));
    end
    check("pre_rst_out", ALU_OUT, sweep_tbl[2]);
    step(16'd12, 16'd5, 4'd3, 1'b1, 16'd0, 1'b0, "mid_rst");
    for (int i = 3; i < 16; i++) begin
      step(16'd12, 16'd5, 4'(i), 1'b0, sweep_tbl[i], 1'b0, $sformatf("resume%0d", i));
    end

    // A few random operations against the model
    for (int i = 0; i < 24; i++) begin
      op(16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 4'($urandom_range(0, 15)),
         $sformatf("rand%0d", i));
    end

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_16b
`default_nettype wire
